// File: rtl/fifo_stream_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_out_pkg
// Brief    : Shared sizing constants, types and pointer helper for the
//            FIFO read-side stream drain stage.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_stream_out_pkg;

  localparam int BUF_DEPTH = 3;
  localparam int PTR_W     = 2;
  localparam int OCC_W     = 2;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [OCC_W-1:0] occ_t;

  // Circular-buffer pointer advance; wraps after the last entry, not at 2^PTR_W.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage : fifo_stream_out_pkg
`default_nettype wire

// File: rtl/fifo_stream_out_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_out_if
// Brief    : FIFO read port plus valid/ready stream bundle for the drain stage.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_stream_out_if #(
  parameter int WIDTH = 8
);

  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  // Drain stage view: pops the FIFO and sources the stream.
  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  // Environment view: the FIFO and the stream consumer.
  modport slave (
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );

endinterface : fifo_stream_out_if
`default_nettype wire

// File: rtl/fifo_stream_out_stream_buf3.sv
`default_nettype none
// ============================================================================
// Module   : stream_buf3
// Brief    : Three-entry circular prefetch buffer with push, pop and clear.
// Revision : 1.0 - initial release
// ============================================================================
module stream_buf3
  import fifo_stream_out_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic             rclk,
  input  wire logic             rst_n,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic             i_clear,
  input  wire logic [WIDTH-1:0] i_din,
  output logic      [WIDTH-1:0] o_dout,
  output logic                  o_valid,
  output occ_t                  o_occ
);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  ptr_t             r_wr_ptr;
  ptr_t             r_rd_ptr;
  occ_t             r_occ;
  occ_t             w_occ_next;

  always_comb begin
    w_occ_next = r_occ;
    case ({i_push, i_pop})
      2'b10:   w_occ_next = r_occ + occ_t'(1);
      2'b01:   w_occ_next = r_occ - occ_t'(1);
      default: w_occ_next = r_occ;
    endcase
  end

  // Clear wins over a same-cycle push so a flushed in-flight word is dropped.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      r_occ <= w_occ_next;
    end
  end

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_valid = (r_occ != '0);
  assign o_occ   = r_occ;

endmodule : stream_buf3
`default_nettype wire

// File: rtl/fifo_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_out
// Brief    : Async-FIFO read-side drain: converts empty/rd_en/dout into a
//            valid/ready stream with prefetch, flush and transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_out
  import fifo_stream_out_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  wire logic             rclk,
  input  wire logic             rst_n,
  input  wire logic             flush,
  fifo_stream_out_if.master     bus,
  output occ_t                  occ,
  output logic      [CNT_W-1:0] word_cnt
);

  logic             r_inflight;
  logic [CNT_W-1:0] r_word_cnt;
  logic [OCC_W:0]   w_occ_sum;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [WIDTH-1:0] w_head;
  occ_t             w_occ;

  // Issue decision uses only registered occupancy and the in-flight flag,
  // so m_ready never reaches fifo_rd_en combinationally.
  assign w_occ_sum = {1'b0, w_occ} + {{OCC_W{1'b0}}, r_inflight};
  assign w_issue   = rst_n & ~bus.fifo_empty & ~flush
                   & (w_occ_sum < (OCC_W + 1)'(BUF_DEPTH));

  assign w_push = r_inflight & ~flush;
  assign w_pop  = w_valid & bus.m_ready;

  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  // Accepted beats in a flush cycle still count.
  always_ff @(posedge rclk) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + CNT_W'(1);
    end
  end

  stream_buf3 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .rclk    (rclk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_din   (bus.fifo_dout),
    .o_dout  (w_head),
    .o_valid (w_valid),
    .o_occ   (w_occ)
  );

  assign bus.fifo_rd_en = w_issue;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head;
  assign occ            = w_occ;
  assign word_cnt       = r_word_cnt;

endmodule : fifo_stream_out
`default_nettype wire

// File: tb/tb_fifo_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_out
// Brief    : Directed and randomised self-checking bench for fifo_stream_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_out;

  logic        rclk  = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  occ, occ4;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;

  fifo_stream_out_if #(.WIDTH(8)) bus  ();
  fifo_stream_out_if #(.WIDTH(8)) bus4 ();

  always #5 rclk = ~rclk;

  fifo_stream_out #(.WIDTH(8), .CNT_W(16)) u_dut (
    .rclk     (rclk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .occ      (occ),
    .word_cnt (word_cnt)
  );

  // Narrow-counter twin fed with identical inputs; only its counter is checked.
  fifo_stream_out #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .rclk     (rclk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus4),
    .occ      (occ4),
    .word_cnt (word_cnt4)
  );

  assign bus4.fifo_empty = bus.fifo_empty;
  assign bus4.fifo_dout  = bus.fifo_dout;
  assign bus4.m_ready    = bus.m_ready;

  // FIFO model with one-cycle registered read latency.
  logic [7:0] mem [0:8191];
  int         wr_idx = 0;
  int         rd_idx = 0;
  logic       force_empty = 1'b0;

  assign bus.fifo_empty = (rd_idx == wr_idx) || force_empty;

  always @(posedge rclk) begin
    if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_dout <= mem[rd_idx];
      rd_idx        <= rd_idx + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_idx] = d;
    wr_idx++;
  endtask

  // Checks n in-order beats starting at value first; m_ready must already be 1.
  task automatic collect(input string tag, input int n, input logic [7:0] first, input int bound);
    int         got = 0;
    int         cyc = 0;
    logic [7:0] e   = first;
    while (got < n && cyc < bound) begin
      if (bus.m_valid) begin
        chk(tag, {24'd0, bus.m_data}, {24'd0, e});
        e++;
        got++;
      end
      @(negedge rclk);
      cyc++;
    end
    chk({tag, "_count"}, got, n);
  endtask

  int base;
  int exp_idx;
  int acc;
  int cyc;

  initial begin
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push_word(8'(i));

    // Reset with a non-empty FIFO.
    repeat (3) @(negedge rclk);
    chk("rst_rd_en",    bus.fifo_rd_en, 0);
    chk("rst_m_valid",  bus.m_valid,    0);
    chk("rst_m_data",   bus.m_data,     0);
    chk("rst_occ",      occ,            0);
    chk("rst_word_cnt", word_cnt,       0);
    chk("rst_pops",     rd_idx,         0);

    // Streaming: first valid two edges after release, then 16 contiguous beats.
    rst_n = 1'b1;
    #1 chk("strm_rd_en_first", bus.fifo_rd_en, 1);
    @(negedge rclk);
    chk("strm_latency_not_yet", bus.m_valid, 0);
    @(negedge rclk);
    for (int i = 0; i < 16; i++) begin
      chk("strm_valid", bus.m_valid, 1);
      chk("strm_data",  bus.m_data,  i + 1);
      @(negedge rclk);
    end
    chk("strm_done_valid", bus.m_valid,    0);
    chk("strm_done_rd_en", bus.fifo_rd_en, 0);
    chk("strm_word_cnt",   word_cnt,       16);
    chk("strm_cnt4_wrap",  word_cnt4,      0);

    // Backpressure: prefetch stops at three words, head holds.
    base = rd_idx;
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_word(8'(i));
    repeat (6) @(negedge rclk);
    chk("bp_occ",   occ,             3);
    chk("bp_pops",  rd_idx - base,   3);
    chk("bp_rd_en", bus.fifo_rd_en,  0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_hold", bus.m_valid, 1);
      chk("bp_data_hold",  bus.m_data,  8'h01);
      @(negedge rclk);
    end
    chk("bp_pops_hold", rd_idx - base, 3);
    bus.m_ready = 1'b1;
    @(negedge rclk);
    chk("bp_word_cnt17", word_cnt,  17);
    chk("cnt4_wrap_17",  word_cnt4, 1);
    collect("bp_beat", 5, 8'h02, 20);
    chk("bp_word_cnt", word_cnt,  22);
    chk("bp_cnt4",     word_cnt4, 6);

    // Flush with two buffered words and one in flight.
    base = rd_idx;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h31 + 8'(i));
    repeat (3) @(negedge rclk);
    chk("fl_occ_pre",  occ,            2);
    chk("fl_pops_pre", rd_idx - base,  3);
    flush = 1'b1;
    #1 chk("fl_rd_en", bus.fifo_rd_en, 0);
    @(negedge rclk);
    flush = 1'b0;
    chk("fl_occ",     occ,           0);
    chk("fl_valid",   bus.m_valid,   0);
    chk("fl_pops",    rd_idx - base, 3);
    bus.m_ready = 1'b1;
    collect("fl_resume", 2, 8'h34, 20);
    chk("fl_word_cnt", word_cnt, 24);

    // Drain to empty.
    push_word(8'hA9);
    push_word(8'hAA);
    collect("drain_beat", 2, 8'hA9, 20);
    for (int i = 0; i < 3; i++) begin
      chk("drain_valid", bus.m_valid,    0);
      chk("drain_rd_en", bus.fifo_rd_en, 0);
      @(negedge rclk);
    end
    chk("drain_word_cnt", word_cnt, 26);

    // Random m_ready and FIFO-empty gaps against an in-order scoreboard.
    exp_idx = wr_idx;
    acc     = 26;
    for (int i = 0; i < 6000; i++) push_word(8'($urandom));
    for (int c = 0; c < 10000; c++) begin
      @(negedge rclk);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 3) == 0);
      if (bus.m_valid && bus.m_ready) begin
        chk("rand_beat", {24'd0, bus.m_data}, {24'd0, mem[exp_idx]});
        exp_idx++;
        acc++;
      end
    end
    @(negedge rclk);
    bus.m_ready = 1'b1;
    force_empty = 1'b0;
    cyc = 0;
    while ((exp_idx < wr_idx || bus.m_valid) && cyc < 20000) begin
      if (bus.m_valid) begin
        chk("rand_drain_beat", {24'd0, bus.m_data}, {24'd0, mem[exp_idx]});
        exp_idx++;
        acc++;
      end
      @(negedge rclk);
      cyc++;
    end
    chk("rand_all_delivered", exp_idx,   wr_idx);
    chk("rand_word_cnt",      word_cnt,  acc % 65536);
    chk("rand_cnt4",          word_cnt4, acc % 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_stream_out
`default_nettype wire
